// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_pkg
// Description : Shared constants and types for the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_fetch_pkg;

    localparam int          c_inst_addr_w = 32;
    localparam int          c_inst_w      = 32;
    localparam logic [31:0] c_zero_word   = 32'h0000_0000;
    localparam logic        c_stop        = 1'b1;
    localparam logic        c_not_stop    = 1'b0;
    localparam logic        c_chip_enable = 1'b1;
    localparam logic        c_chip_disable = 1'b0;
    localparam logic        c_jump_branch = 1'b1;

    // One buffered fetch result travelling toward decode.
    typedef struct packed {
        logic [c_inst_addr_w-1:0] pc;
        logic [c_inst_w-1:0]      inst;
    } fetch_pair_t;

    // Occupancy counters must be able to represent the value DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : inst_fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO with clear, combinational head and count.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_depth = (c_ptr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_push;
    logic               w_pop;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_pop  = pop && (r_count != '0);
    assign w_push = push && ((r_count != c_depth) || w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= r_count + (c_ptr_w + 1)'(w_push) - (c_ptr_w + 1)'(w_pop);
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : In-order instruction fetch with credit flow control, redirect
//               and stale-response discard, feeding a buffered decode channel.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        ce,
    input  logic        jump_branch_flag,
    input  logic [31:0] jump_branch_addr,
    output logic        stall_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    input  logic        id_ready
);

    localparam int c_cnt_w = cnt_width(DEPTH);
    localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w:0]   c_depth_ext = (c_cnt_w + 1)'(DEPTH);

    logic [c_cnt_w-1:0] w_outstanding;
    logic [c_cnt_w-1:0] w_fifo_cnt;
    logic [c_cnt_w-1:0] w_live;
    logic [c_cnt_w:0]   w_credit_used;
    logic [c_cnt_w-1:0] r_drop;
    logic               r_redir_pend;
    logic [31:0]        r_redir_addr;
    logic               w_flush;
    logic               w_issue_ok;
    logic               w_fire;
    logic               w_rsp;
    logic               w_rsp_keep;
    logic               w_pop;
    logic [31:0]        w_rsp_pc;
    fetch_pair_t        w_push_pair;
    fetch_pair_t        w_head_pair;

    assign w_flush = (jump_branch_flag == c_jump_branch);
    assign w_live  = w_outstanding - r_drop;
    assign w_pop   = id_valid && id_ready;

    // The entry leaving toward decode this cycle frees its slot, which keeps
    // single-cycle memory streaming at one instruction per cycle.
    assign w_credit_used = {1'b0, w_fifo_cnt} + {1'b0, w_live}
                         - {{c_cnt_w{1'b0}}, w_pop};

    assign w_issue_ok = rst
                     && (ce == c_chip_enable)
                     && !w_flush
                     && (w_outstanding < c_depth)
                     && (w_credit_used < c_depth_ext);

    assign imem_req_valid = w_issue_ok;
    assign imem_req_addr  = r_redir_pend ? r_redir_addr : pc;
    assign w_fire         = imem_req_valid && imem_req_ready;

    // The generator advances only when its own address was accepted, or when
    // it must load the redirect target.
    assign stall_pc = ((w_fire && !r_redir_pend) || (rst && w_flush)) ? c_not_stop : c_stop;

    assign w_rsp      = imem_rsp_valid && (w_outstanding != '0);
    assign w_rsp_keep = w_rsp && (r_drop == '0) && !w_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop       <= '0;
            r_redir_pend <= 1'b0;
            r_redir_addr <= c_zero_word;
        end else if (w_flush) begin
            r_drop       <= w_outstanding - c_cnt_w'(w_rsp) + c_cnt_w'(w_fire);
            r_redir_addr <= jump_branch_addr;
            r_redir_pend <= 1'b1;
        end else begin
            if (w_rsp && (r_drop != '0)) begin
                r_drop <= r_drop - c_cnt_w'(1);
            end
            if (w_fire) begin
                r_redir_pend <= 1'b0;
            end
        end
    end

    // Address of every in-flight request; its occupancy is the outstanding count.
    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk       (clk),
        .rst       (rst),
        .clr       (1'b0),
        .push      (w_fire),
        .push_data (imem_req_addr),
        .pop       (w_rsp),
        .head      (w_rsp_pc),
        .count     (w_outstanding)
    );

    assign w_push_pair.pc   = w_rsp_pc;
    assign w_push_pair.inst = imem_rsp_data;

    fetch_fifo #(
        .WIDTH ($bits(fetch_pair_t)),
        .DEPTH (DEPTH)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .clr       (w_flush),
        .push      (w_rsp_keep),
        .push_data (w_push_pair),
        .pop       (w_pop),
        .head      (w_head_pair),
        .count     (w_fifo_cnt)
    );

    assign id_valid = (w_fifo_cnt != '0);
    assign id_pc    = w_head_pair.pc;
    assign id_inst  = w_head_pair.inst;

    a_rsp_needs_request : assert property (
        @(posedge clk) disable iff (!rst) !(imem_rsp_valid && (w_outstanding == '0))
    );

endmodule : inst_fetch
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch
// Description : Directed self-checking bench for inst_fetch with a
//               variable-latency memory model and a PC generator model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_gen;
    logic        ce;
    logic        jump_branch_flag;
    logic [31:0] jump_branch_addr;
    logic        stall_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inst_fetch #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc               (pc_gen),
        .ce               (ce),
        .jump_branch_flag (jump_branch_flag),
        .jump_branch_addr (jump_branch_addr),
        .stall_pc         (stall_pc),
        .imem_req_valid   (imem_req_valid),
        .imem_req_addr    (imem_req_addr),
        .imem_req_ready   (imem_req_ready),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .id_valid         (id_valid),
        .id_pc            (id_pc),
        .id_inst          (id_inst),
        .id_ready         (id_ready)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory: a request accepted in cycle c answers in cycle c+lat, in order.
    int          lat = 1;
    int          cyc = 0;
    logic [31:0] q_addr[$];
    int          q_due[$];
    logic        mem_fire_s;
    logic [31:0] mem_addr_s;

    always begin
        @(posedge clk);
        mem_fire_s = rst && imem_req_valid && imem_req_ready;
        mem_addr_s = imem_req_addr;
        #1;
        if (!rst) begin
            q_addr.delete();
            q_due.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end else begin
            if (mem_fire_s) begin
                q_addr.push_back(mem_addr_s);
                q_due.push_back(cyc + lat);
            end
            cyc++;
            if (q_due.size() > 0 && q_due[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = inst_of(q_addr.pop_front());
                void'(q_due.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
        end
    end

    // PC generator: loads target+4 on redirect, else advances when released.
    logic        pg_stall_s;
    logic        pg_flag_s;
    logic [31:0] pg_addr_s;
    logic        pg_rst_s;

    always begin
        @(posedge clk);
        pg_stall_s = stall_pc;
        pg_flag_s  = jump_branch_flag;
        pg_addr_s  = jump_branch_addr;
        pg_rst_s   = rst;
        #1;
        if (!rst) begin
            pc_gen = 32'h0;
        end else if (pg_rst_s) begin
            if (pg_flag_s)          pc_gen = pg_addr_s + 32'd4;
            else if (!pg_stall_s)   pc_gen = pc_gen + 32'd4;
        end
    end

    logic [63:0] log_q[$];

    always @(negedge clk) begin
        if (rst && id_valid && id_ready) log_q.push_back({id_pc, id_inst});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Delivered sequence must be base, base+4, ... with no gap or repeat and
    // account for every address the generator handed out.
    task automatic check_run(input string tag, input logic [31:0] base);
        chk({tag, " depth"}, 32'(log_q.size() >= 2), 32'd1);
        chk({tag, " count"}, pc_gen, base + 32'(4 * log_q.size()));
        for (int i = 0; i < log_q.size(); i++) begin
            chk({tag, " pc"},   log_q[i][63:32], base + 32'(4 * i));
            chk({tag, " inst"}, log_q[i][31:0],  inst_of(base + 32'(4 * i)));
        end
    endtask

    task automatic drain();
        @(posedge clk); #1;
        ce = 1'b0;
        jump_branch_flag = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        rst              = 1'b0;
        ce               = 1'b1;
        id_ready         = 1'b1;
        imem_req_ready   = 1'b1;
        jump_branch_flag = 1'b0;
        jump_branch_addr = 32'h0;
        imem_rsp_valid   = 1'b0;
        imem_rsp_data    = 32'h0;
        pc_gen           = 32'h0;

        // Reset held with ce high
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst id_valid",  32'(id_valid),       32'd0);
        chk("rst stall_pc",  32'(stall_pc),       32'd1);
        chk("rst id_pc",     id_pc,               32'h0);
        chk("rst id_inst",   id_inst,             32'h0);

        // Streaming with single-cycle memory
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("first req_valid", 32'(imem_req_valid), 32'd1);
        chk("first req_addr",  imem_req_addr,       32'h0);
        chk("first stall_pc",  32'(stall_pc),       32'd0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("stream id_valid early", 32'(id_valid), 32'd0);
            end else begin
                chk("stream id_valid", 32'(id_valid), 32'd1);
                chk("stream id_pc",    id_pc,         32'((k - 2) * 4));
                chk("stream id_inst",  id_inst,       inst_of(32'((k - 2) * 4)));
            end
        end

        // Back-pressure from decode
        @(posedge clk); #1;
        id_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("bp req_valid", 32'(imem_req_valid), 32'd0);
        chk("bp stall_pc",  32'(stall_pc),       32'd1);
        chk("bp id_valid",  32'(id_valid),       32'd1);
        @(posedge clk); #1;
        id_ready = 1'b1;
        repeat (6) @(posedge clk);
        drain();
        check_run("stream", 32'h0);

        // Flush with two stale requests in a 3-cycle memory
        log_q.delete();
        lat = 3;
        ce  = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        jump_branch_flag = 1'b1;
        jump_branch_addr = 32'h100;
        @(negedge clk);
        chk("flush stall_pc",  32'(stall_pc),       32'd0);
        chk("flush req_valid", 32'(imem_req_valid), 32'd0);
        @(posedge clk); #1;
        jump_branch_flag = 1'b0;
        @(negedge clk);
        chk("flush blocked req_valid", 32'(imem_req_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("flush target req_valid", 32'(imem_req_valid), 32'd1);
        chk("flush target addr",      imem_req_addr,       32'h100);
        chk("flush target stall_pc",  32'(stall_pc),       32'd1);
        @(negedge clk);
        chk("flush seq addr",     imem_req_addr,  32'h104);
        chk("flush seq stall_pc", 32'(stall_pc),  32'd0);
        repeat (12) @(posedge clk);
        drain();
        check_run("flush", 32'h100);

        // Flush colliding with a response and a decode pop
        log_q.delete();
        lat = 1;
        ce  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        jump_branch_flag = 1'b1;
        jump_branch_addr = 32'h200;
        @(negedge clk);
        chk("coll id_valid before",  32'(id_valid),       32'd1);
        chk("coll rsp present",      32'(imem_rsp_valid), 32'd1);
        chk("coll req_valid",        32'(imem_req_valid), 32'd0);
        @(posedge clk); #1;
        jump_branch_flag = 1'b0;
        log_q.delete();
        @(negedge clk);
        chk("coll id_valid after", 32'(id_valid),       32'd0);
        chk("coll target valid",   32'(imem_req_valid), 32'd1);
        chk("coll target addr",    imem_req_addr,       32'h200);
        repeat (8) @(posedge clk);
        drain();
        check_run("collide", 32'h200);

        // Back-to-back redirects before the first target issues
        log_q.delete();
        ce = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        jump_branch_flag = 1'b1;
        jump_branch_addr = 32'h200;
        @(posedge clk); #1;
        jump_branch_addr = 32'h300;
        log_q.delete();
        @(negedge clk);
        chk("redir2 req_valid", 32'(imem_req_valid), 32'd0);
        chk("redir2 stall_pc",  32'(stall_pc),       32'd0);
        @(posedge clk); #1;
        jump_branch_flag = 1'b0;
        @(negedge clk);
        chk("redir2 target valid", 32'(imem_req_valid), 32'd1);
        chk("redir2 target addr",  imem_req_addr,       32'h300);
        repeat (8) @(posedge clk);
        drain();
        check_run("redir2", 32'h300);

        // Reset in the middle of streaming
        ce = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst req_valid", 32'(imem_req_valid), 32'd0);
        chk("midrst id_valid",  32'(id_valid),       32'd0);
        chk("midrst stall_pc",  32'(stall_pc),       32'd1);
        chk("midrst id_pc",     id_pc,               32'h0);
        chk("midrst id_inst",   id_inst,             32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_inst_fetch
`default_nettype wire
